// File: rtl/fb_page_scanner.sv
// Walks a monochrome framebuffer in SSD1306 page order and streams each column byte downstream.
// Optional continuous refresh when FB_SCAN_AUTO_EN is defined.
module fb_page_scanner #(
  parameter int unsigned H_PIXELS = 128,
  parameter int unsigned V_PIXELS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  input  logic       fb_rst_complete,
  output logic       fb_re,
  output logic [7:0] fb_r_xpos,
  output logic [7:0] fb_r_ypos,
  output logic       fb_r_mode,
  input  logic       fb_r_data_valid,
  input  logic [7:0] fb_dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_sop,
  output logic [2:0] out_page
);

  localparam int unsigned Pages = V_PIXELS / 8;
  localparam int unsigned ColW  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned PageW = (Pages > 1) ? $clog2(Pages) : 1;
  localparam logic [ColW-1:0]  LastCol  = ColW'(H_PIXELS - 1);
  localparam logic [PageW-1:0] LastPage = PageW'(Pages - 1);

  typedef enum logic [2:0] {StIdle, StReq, StRelease, StEmit, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [ColW-1:0]  r_col, w_col_d;
  logic [PageW-1:0] r_page, w_page_d;
  logic             r_busy, w_busy_d;
  logic             r_frame_done, w_frame_done_d;
  logic             r_fb_re, w_fb_re_d;
  logic             r_out_valid, w_out_valid_d;
  logic [7:0]       r_out_data, w_out_data_d;
  logic             r_out_sof, w_out_sof_d;
  logic             r_out_sop, w_out_sop_d;
  logic [2:0]       r_out_page, w_out_page_d;
  logic             w_last_col, w_last_page;

  assign w_last_col  = (r_col == LastCol);
  assign w_last_page = (r_page == LastPage);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_page       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_fb_re      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sof    <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_page   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_col        <= w_col_d;
      r_page       <= w_page_d;
      r_busy       <= w_busy_d;
      r_frame_done <= w_frame_done_d;
      r_fb_re      <= w_fb_re_d;
      r_out_valid  <= w_out_valid_d;
      r_out_data   <= w_out_data_d;
      r_out_sof    <= w_out_sof_d;
      r_out_sop    <= w_out_sop_d;
      r_out_page   <= w_out_page_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_col_d        = r_col;
    w_page_d       = r_page;
    w_busy_d       = r_busy;
    w_frame_done_d = 1'b0;
    w_fb_re_d      = r_fb_re;
    w_out_valid_d  = r_out_valid;
    w_out_data_d   = r_out_data;
    w_out_sof_d    = r_out_sof;
    w_out_sop_d    = r_out_sop;
    w_out_page_d   = r_out_page;

    case (r_state)
      StIdle: begin
        if (start && fb_rst_complete) begin
          w_col_d   = '0;
          w_page_d  = '0;
          w_busy_d  = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        // An issued read always completes; a new one waits for the clear to be finished.
        if (r_fb_re) begin
          if (fb_r_data_valid) begin
            w_out_data_d = fb_dout;
            w_out_sof_d  = (r_col == '0) && (r_page == '0);
            w_out_sop_d  = (r_col == '0);
            w_out_page_d = 3'(r_page);
            w_fb_re_d    = 1'b0;
            w_state_d    = StRelease;
          end
        end else begin
          w_fb_re_d = fb_rst_complete;
        end
      end
      StRelease: begin
        if (!fb_r_data_valid) begin
          w_out_valid_d = 1'b1;
          w_state_d     = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          w_out_valid_d = 1'b0;
          if (w_last_col) begin
            w_col_d = '0;
            if (w_last_page) begin
              w_page_d       = '0;
              w_frame_done_d = 1'b1;
              w_state_d      = StDone;
            end else begin
              w_page_d  = r_page + PageW'(1);
              w_state_d = StReq;
            end
          end else begin
            w_col_d   = r_col + ColW'(1);
            w_state_d = StReq;
          end
        end
      end
      StDone: begin
`ifdef FB_SCAN_AUTO_EN
        w_state_d = StReq;
`else
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
`endif
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign fb_re      = r_fb_re;
  assign fb_r_xpos  = 8'(r_col);
  assign fb_r_ypos  = 8'({r_page, 3'b000});
  assign fb_r_mode  = 1'b1;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sof    = r_out_sof;
  assign out_sop    = r_out_sop;
  assign out_page   = r_out_page;

endmodule

// File: tb/tb_fb_page_scanner.sv
// Bench for fb_page_scanner: framebuffer model with x^page bytes, random downstream stalls.
module tb_fb_page_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, frame_done;
  logic       fb_rst_complete = 1'b0;
  logic       fb_re;
  logic [7:0] fb_r_xpos, fb_r_ypos;
  logic       fb_r_mode;
  logic       fb_r_data_valid;
  logic [7:0] fb_dout;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_sof, out_sop;
  logic [2:0] out_page;

  fb_page_scanner #(.H_PIXELS(128), .V_PIXELS(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .frame_done      (frame_done),
    .fb_rst_complete (fb_rst_complete),
    .fb_re           (fb_re),
    .fb_r_xpos       (fb_r_xpos),
    .fb_r_ypos       (fb_r_ypos),
    .fb_r_mode       (fb_r_mode),
    .fb_r_data_valid (fb_r_data_valid),
    .fb_dout         (fb_dout),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sof         (out_sof),
    .out_sop         (out_sop),
    .out_page        (out_page)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Framebuffer model: column byte = x ^ page, configurable response delay and hold.
  int unsigned fb_delay = 0;
  int unsigned fb_hold  = 0;
  int unsigned m_cnt, m_hcnt;
  int          reads = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_r_data_valid <= 1'b0;
      fb_dout         <= 8'h00;
      m_cnt           <= 0;
      m_hcnt          <= 0;
    end else if (!fb_r_data_valid) begin
      if (fb_re) begin
        if (m_cnt >= fb_delay) begin
          fb_r_data_valid <= 1'b1;
          fb_dout         <= fb_r_xpos ^ (fb_r_ypos >> 3);
          m_cnt           <= 0;
          reads           <= reads + 1;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (!fb_re) begin
      if (m_hcnt >= fb_hold) begin
        fb_r_data_valid <= 1'b0;
        m_hcnt          <= 0;
      end else begin
        m_hcnt <= m_hcnt + 1;
      end
    end
  end

  // Downstream sink and stream monitor, all sampled on the falling edge.
  int unsigned stall_pct = 0;
  logic [7:0]  got_data[$];
  logic [4:0]  got_mark[$];
  bit          prev_stall = 0;
  logic [12:0] prev_word;
  bit          re_prev = 0;
  int          done_cnt = 0;
  int          re_rises = 0;
  int          busy_low = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      re_prev    = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_data, out_sof, out_sop, out_page}, {1'b1, prev_word});
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_mark.push_back({out_sof, out_sop, out_page});
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_sof, out_sop, out_page};
      if (frame_done) done_cnt++;
      if (fb_re && !re_prev) re_rises++;
      re_prev = fb_re;
      if (!busy) busy_low++;
    end
  end

  function automatic logic [33:0] outs();
    return {busy, frame_done, fb_re, out_valid, out_sof, out_sop, fb_r_mode,
            fb_r_xpos, fb_r_ypos, out_data, out_page};
  endfunction

  localparam logic [33:0] RstOuts = {7'b0000001, 27'd0};

  function automatic void check_bytes(input string tag, input int n_exp);
    int m;
    logic [7:0] ed;
    logic [4:0] em;
    check({tag, "_count"}, got_data.size(), n_exp);
    for (int n = 0; n < got_data.size() && n < n_exp; n++) begin
      m  = n % 1024;
      ed = 8'((m % 128) ^ (m / 128));
      em = {m == 0, (m % 128) == 0, 3'(m / 128)};
      check({tag, "_data"}, got_data[n], ed);
      check({tag, "_mark"}, got_mark[n], em);
    end
  endfunction

  typedef struct {
    int unsigned delay;
    int unsigned hold;
    int unsigned stall;
    bit          drop_cmpl;
    int          exp_bytes;
    int          exp_done;
    int          exp_sops;
  } vec_t;

  task automatic run_frame(input vec_t v, input string tag);
    int base_reads, base_done, cyc, rises0, sops;
    bit dropped;
    fb_delay   = v.delay;
    fb_hold    = v.hold;
    stall_pct  = v.stall;
    got_data.delete();
    got_mark.delete();
    base_reads = reads;
    base_done  = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc     = 0;
    dropped = 0;
    while (done_cnt == base_done && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 40);  // start while busy must be ignored
      if (v.drop_cmpl && !dropped && got_data.size() >= 500) begin
        dropped = 1;
        fb_rst_complete = 1'b0;
        rises0 = re_rises;
        repeat (30) @(negedge clk);
        check({tag, "_drop_no_read"}, re_rises - rises0, 0);
        check({tag, "_drop_re_low"}, fb_re, 1'b0);
        fb_rst_complete = 1'b1;
      end
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check({tag, "_frame_done"}, done_cnt - base_done, v.exp_done);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_reads"}, reads - base_reads, v.exp_bytes);
    sops = 0;
    foreach (got_mark[i]) if (got_mark[i][3]) sops++;
    check({tag, "_sops"}, sops, v.exp_sops);
    check_bytes(tag, v.exp_bytes);
  endtask

  vec_t vecs[4];
  int   base, cyc;

  initial begin
    vecs[0] = '{delay: 0, hold: 0, stall: 0,  drop_cmpl: 0, exp_bytes: 1024, exp_done: 1, exp_sops: 8};
    vecs[1] = '{delay: 0, hold: 0, stall: 50, drop_cmpl: 0, exp_bytes: 1024, exp_done: 1, exp_sops: 8};
    vecs[2] = '{delay: 5, hold: 3, stall: 0,  drop_cmpl: 0, exp_bytes: 1024, exp_done: 1, exp_sops: 8};
    vecs[3] = '{delay: 1, hold: 1, stall: 30, drop_cmpl: 1, exp_bytes: 1024, exp_done: 1, exp_sops: 8};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), RstOuts);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", outs(), RstOuts);

    // Start without a finished framebuffer clear is ignored.
    base = re_rises;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    check("no_cmpl_busy", busy, 1'b0);
    check("no_cmpl_no_read", re_rises - base, 0);
    fb_rst_complete = 1'b1;

`ifdef FB_SCAN_AUTO_EN
    got_data.delete();
    got_mark.delete();
    base = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = busy_low;
    while (done_cnt - base < 2 && got_data.size() < 2100 && n_tests < 100000) begin
      @(negedge clk);
      if (got_data.size() > 2100) break;
      if ($time > 64'd400000) break;
    end
    check("auto_frames", done_cnt - base, 2);
    check("auto_busy_never_low", busy_low - cyc, 0);
    check_bytes("auto", 2048);
    rst_n = 1'b0;
    #1 check("auto_reset_outputs", outs(), RstOuts);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`else
    foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a frame, then a clean restart.
    fb_delay  = 0;
    fb_hold   = 0;
    stall_pct = 0;
    got_data.delete();
    got_mark.delete();
    base = done_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (got_data.size() < 300 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset_reached_300", got_data.size() >= 300, 1'b1);
    rst_n = 1'b0;
    #1 check("midreset_outputs", outs(), RstOuts);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midreset_no_done", done_cnt - base, 0);
    check("midreset_idle", outs(), RstOuts);
    run_frame(vecs[0], "restart");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
